// File: rtl/disp_seq_ctrl_pkg.sv
// disp_pkg: shared types and sizes for the result-display sequencer.
//   state_t      : sequencer states
//   NUM_RESULTS  : number of results shown per pass
//   IDX_W/RES_W  : index and result widths
//   LAST_IDX     : index of the final result in a pass
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int NUM_RESULTS = 8;
  localparam int IDX_W       = 3;
  localparam int RES_W       = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESULTS - 1);

endpackage

// File: rtl/disp_seq_ctrl_dwell_timer.sv
// dwell_timer: phase timer shared by the SHOW and GAP phases.
//   clk      : system clock
//   reset    : synchronous active-low reset
//   clear    : force the count to zero
//   enable   : count this cycle
//   terminal : phase length in cycles
//   expire   : high in the last cycle of the phase (count == terminal-1);
//              the count wraps to zero on that edge
module dwell_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == (terminal - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expire ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/disp_seq_ctrl.sv
// disp_seq_ctrl: steps the eight convolution results onto the 7-seg display.
// A start snapshots all eight inputs; each value is shown for DWELL_CYCLES,
// followed by GAP_CYCLES blank cycles. One pass, or loop while loop_en.
//   clk, reset        : system clock, synchronous active-low reset
//   start_d           : start request (honoured only when idle)
//   stop              : abort to idle (beats start_d)
//   loop_en           : wrap from idx 7 back to idx 0
//   C_xx_2x2/C_xx_3x3 : results, shown at idx 0-3 and 4-7
//   convolution, idx  : value being presented and its index
//   blank             : display must be dark
//   busy              : sequence in progress
//   done              : one-cycle pulse at the end of a non-looping pass
//
// state | meaning
// IDLE  | waiting for start_d, display blank
// SHOW  | presenting snap[idx] for DWELL_CYCLES
// GAP   | blank for GAP_CYCLES, convolution/idx held
module disp_seq_ctrl
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int GAP_CYCLES   = 10_000_000,
  parameter int CNT_W        = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_d,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [RES_W-1:0] C_11_2x2,
  input  logic [RES_W-1:0] C_12_2x2,
  input  logic [RES_W-1:0] C_21_2x2,
  input  logic [RES_W-1:0] C_22_2x2,
  input  logic [RES_W-1:0] C_11_3x3,
  input  logic [RES_W-1:0] C_12_3x3,
  input  logic [RES_W-1:0] C_21_3x3,
  input  logic [RES_W-1:0] C_22_3x3,
  output logic [RES_W-1:0] convolution,
  output logic [IDX_W-1:0] idx,
  output logic             blank,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] DWELL_T = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(GAP_CYCLES);
  localparam bit               HAS_GAP = (GAP_CYCLES != 0);

  state_t           state;
  logic [RES_W-1:0] snap [NUM_RESULTS];
  logic [IDX_W-1:0] idx_next;
  logic [CNT_W-1:0] terminal;
  logic             timer_clear;
  logic             timer_en;
  logic             expire;
  logic             advance;

  // The timer idles at zero so SHOW always starts from a fresh count;
  // SHOW->GAP and GAP->SHOW rely on the wrap inside the timer.
  assign timer_clear = (state == IDLE) || stop;
  assign timer_en    = (state != IDLE);
  assign terminal    = (state == GAP) ? GAP_T : DWELL_T;
  assign idx_next    = idx + IDX_W'(1);

  // Without a gap the end of SHOW moves straight to the next value.
  assign advance = expire && ((state == GAP) || ((state == SHOW) && !HAS_GAP));

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (terminal),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      convolution <= '0;
      idx         <= '0;
      blank       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < NUM_RESULTS; i++) snap[i] <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state       <= IDLE;
        convolution <= '0;
        idx         <= '0;
        blank       <= 1'b1;
        busy        <= 1'b0;
      end else if (advance) begin
        if (idx != LAST_IDX) begin
          idx         <= idx_next;
          convolution <= snap[idx_next];
          blank       <= 1'b0;
          state       <= SHOW;
        end else if (loop_en) begin
          idx         <= '0;
          convolution <= snap[0];
          blank       <= 1'b0;
          state       <= SHOW;
        end else begin
          state       <= IDLE;
          convolution <= '0;
          idx         <= '0;
          blank       <= 1'b1;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start_d) begin
              snap[0]     <= C_11_2x2;
              snap[1]     <= C_12_2x2;
              snap[2]     <= C_21_2x2;
              snap[3]     <= C_22_2x2;
              snap[4]     <= C_11_3x3;
              snap[5]     <= C_12_3x3;
              snap[6]     <= C_21_3x3;
              snap[7]     <= C_22_3x3;
              convolution <= C_11_2x2;
              idx         <= '0;
              blank       <= 1'b0;
              busy        <= 1'b1;
              state       <= SHOW;
            end
          end
          SHOW: begin
            // Only reached with a gap configured; the no-gap case is advance.
            if (expire) begin
              blank <= 1'b1;
              state <= GAP;
            end
          end
          GAP:     ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disp_seq_ctrl.sv
module tb_disp_seq_ctrl;

  localparam int DW = 4;
  localparam int GA = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_d = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] din [8];

  logic [7:0] conv_a, conv_b;
  logic [2:0] idx_a, idx_b;
  logic       blank_a, blank_b, busy_a, busy_b, done_a, done_b;
  logic [13:0] obs_a, obs_b;

  assign obs_a = {conv_a, idx_a, blank_a, busy_a, done_a};
  assign obs_b = {conv_b, idx_b, blank_b, busy_b, done_b};

  always #5 clk = ~clk;

  disp_seq_ctrl #(.DWELL_CYCLES(DW), .GAP_CYCLES(GA), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset_n), .start_d(start_d), .stop(stop), .loop_en(loop_en),
    .C_11_2x2(din[0]), .C_12_2x2(din[1]), .C_21_2x2(din[2]), .C_22_2x2(din[3]),
    .C_11_3x3(din[4]), .C_12_3x3(din[5]), .C_21_3x3(din[6]), .C_22_3x3(din[7]),
    .convolution(conv_a), .idx(idx_a), .blank(blank_a), .busy(busy_a), .done(done_a));

  disp_seq_ctrl #(.DWELL_CYCLES(DW), .GAP_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset_n), .start_d(start_d), .stop(stop), .loop_en(loop_en),
    .C_11_2x2(din[0]), .C_12_2x2(din[1]), .C_21_2x2(din[2]), .C_22_2x2(din[3]),
    .C_11_3x3(din[4]), .C_12_3x3(din[5]), .C_21_3x3(din[6]), .C_22_3x3(din[7]),
    .convolution(conv_b), .idx(idx_b), .blank(blank_b), .busy(busy_b), .done(done_b));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model, k=0 for the gapped instance, k=1 for the gapless one.
  // A running pass is just a cycle count n since the start edge; the value
  // slot and whether it is blank follow from n / period and n % period.
  bit         m_busy [2];
  bit         m_done [2];
  int         m_n    [2];
  logic [7:0] m_snap [2][8];

  function automatic int period(int k);
    return DW + ((k == 0) ? GA : 0);
  endfunction

  function automatic logic [13:0] exp_out(int k);
    int slot, ph;
    if (m_busy[k]) begin
      slot = m_n[k] / period(k);
      ph   = m_n[k] % period(k);
      return {m_snap[k][slot], 3'(slot), (ph >= DW), 1'b1, 1'b0};
    end
    return {8'h00, 3'd0, 1'b1, 1'b0, m_done[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b0;
        m_n[k]    = 0;
        for (int j = 0; j < 8; j++) m_snap[k][j] = 8'h00;
      end else if (stop) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b0;
      end else if (!m_busy[k]) begin
        m_done[k] = 1'b0;
        if (start_d) begin
          m_busy[k] = 1'b1;
          m_n[k]    = 0;
          for (int j = 0; j < 8; j++) m_snap[k][j] = din[j];
        end
      end else begin
        m_n[k]++;
        if (m_n[k] == 8 * period(k)) begin
          if (loop_en) m_n[k] = 0;
          else begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic rand_inputs();
    for (int j = 0; j < 8; j++) din[j] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_d = 1'b1;
    for (int j = 0; j < 8; j++) din[j] = 8'hA5;
    repeat (2) begin
      tick();
      n_chk++;
      if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
        n_fail++;
        $display("FAIL reset: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
      end
    end
    start_d = 1'b0;
    reset_n = 1'b1;
    tick();
    n_chk++;
    if (obs_a !== 14'h0004) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs_a, 14'h0004);
    end
  endtask

  task automatic test_single_pass();
    int t_a = -1, t_b = -1;
    for (int j = 0; j < 8; j++) din[j] = 8'(8'h11 * (j + 1));
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int c = 1; c <= 56; c++) begin
      if (c > 1) tick();
      else begin
        n_chk++;
        if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
          n_fail++;
          $display("FAIL single_start: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
        end
        tick();
      end
      n_chk++;
      if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
        n_fail++;
        $display("FAIL single_pass c=%0d: got a=%h b=%h expected a=%h b=%h", c, obs_a, obs_b, exp_out(0), exp_out(1));
      end
      if (done_a === 1'b1 && t_a < 0) t_a = c;
      if (done_b === 1'b1 && t_b < 0) t_b = c;
    end
    n_chk++;
    if (t_a != 48) begin
      n_fail++;
      $display("FAIL done_time_gap: got %0d expected 48", t_a);
    end
    n_chk++;
    if (t_b != 32) begin
      n_fail++;
      $display("FAIL done_time_nogap: got %0d expected 32", t_b);
    end
  endtask

  task automatic test_loop();
    rand_inputs();
    loop_en = 1'b1;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    repeat (8 * (DW + GA) + 14) begin
      tick();
      n_chk++;
      if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
        n_fail++;
        $display("FAIL loop: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 1'b0;
    n_chk++;
    if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
      n_fail++;
      $display("FAIL loop_stop: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
    end
  endtask

  task automatic test_stop();
    int target = 18 + int'($urandom_range(0, 3));
    rand_inputs();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int c = 0; c < 100 && m_n[0] != target; c++) begin
      tick();
      n_chk++;
      if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
        n_fail++;
        $display("FAIL stop_run: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
      end
    end
    stop = 1'b1;
    start_d = 1'b1;
    tick();
    n_chk++;
    if (obs_a !== 14'h0004) begin
      n_fail++;
      $display("FAIL stop_idle: got %h expected %h", obs_a, 14'h0004);
    end
    // stop and start together while idle: must stay idle
    tick();
    stop = 1'b0;
    start_d = 1'b0;
    n_chk++;
    if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
      n_fail++;
      $display("FAIL stop_start_idle: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
    end
  endtask

  task automatic test_busy_start();
    int target = 12 + int'($urandom_range(0, 3));
    rand_inputs();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int c = 0; c < 100 && m_n[0] != target; c++) tick();
    for (int j = 0; j < 8; j++) din[j] = 8'hFF;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    repeat (8 * (DW + GA) - target + 4) begin
      tick();
      n_chk++;
      if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
        n_fail++;
        $display("FAIL busy_start: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
      end
    end
  endtask

  task automatic test_gap_zero();
    bit blank_seen = 1'b0;
    int t_b = -1;
    rand_inputs();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      n_chk++;
      if (obs_b !== exp_out(1)) begin
        n_fail++;
        $display("FAIL gap_zero c=%0d: got %h expected %h", c, obs_b, exp_out(1));
      end
      if (busy_b === 1'b1 && blank_b !== 1'b0) blank_seen = 1'b1;
      if (done_b === 1'b1 && t_b < 0) t_b = c;
    end
    n_chk++;
    if (blank_seen) begin
      n_fail++;
      $display("FAIL gap_zero_blank: got blank while busy expected none");
    end
    n_chk++;
    if (t_b != 32) begin
      n_fail++;
      $display("FAIL gap_zero_done: got %0d expected 32", t_b);
    end
    repeat (20) tick();
  endtask

  task automatic test_back_to_back();
    rand_inputs();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int c = 0; c < 100 && !m_done[0]; c++) tick();
    n_chk++;
    if (done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: got %b expected 1", done_a);
    end
    rand_inputs();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    repeat (8) begin
      tick();
      n_chk++;
      if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
        n_fail++;
        $display("FAIL back_to_back: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    int target = 30 + int'($urandom_range(0, 5));
    rand_inputs();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int c = 0; c < 100 && m_n[0] != target; c++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_chk++;
    if ({obs_a, obs_b} !== {14'h0004, 14'h0004}) begin
      n_fail++;
      $display("FAIL reset_mid: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, 14'h0004, 14'h0004);
    end
    rand_inputs();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    repeat (30) begin
      tick();
      n_chk++;
      if ({obs_a, obs_b} !== {exp_out(0), exp_out(1)}) begin
        n_fail++;
        $display("FAIL reset_restart: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_out(0), exp_out(1));
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 8; j++) din[j] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_done[k] = 1'b0;
      m_n[k]    = 0;
      for (int j = 0; j < 8; j++) m_snap[k][j] = 8'h00;
    end
    @(negedge clk);
    test_reset();
    test_single_pass();
    test_loop();
    test_stop();
    test_busy_start();
    test_gap_zero();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_seq_ctrl.md
# disp_seq_ctrl

Sequencing controller for the seven-segment result display. On `start_d` it snapshots the eight 8-bit convolution results (four 2x2, four 3x3) and presents them one at a time on `convolution` for a fixed dwell time, with an optional blank gap between values. It can run one pass or loop, and it can be aborted. Its outputs drive the 7-seg scan/decode block directly.

## Interface
- `DWELL_CYCLES`, default 100_000_000: cycles each value is shown. Must be ≥1.
- `GAP_CYCLES`, default 10_000_000: blank cycles after each value. 0 means no gap.
- `CNT_W`, default 27: timer width. Must be ≥ $clog2(max(DWELL_CYCLES, GAP_CYCLES)).
- `clk` in 1: the single system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start_d` in 1: start request. Sampled only in IDLE.
- `stop` in 1: abort the sequence. Has priority over `start_d`.
- `loop_en` in 1: restart at index 0 after index 7 instead of finishing.
- `C_11_2x2`, `C_12_2x2`, `C_21_2x2`, `C_22_2x2` in 8 each: 2x2 results, shown at idx 0–3.
- `C_11_3x3`, `C_12_3x3`, `C_21_3x3`, `C_22_3x3` in 8 each: 3x3 results, shown at idx 4–7.
- `convolution` out 8: value currently presented.
- `idx` out 3: index of the presented value.
- `blank` out 1: display must show nothing while this is high.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse when a non-looping pass completes.

## Operation
- **States:** IDLE, SHOW, GAP. All outputs are registered.
- **Reset values (reset=0 at an edge):** state IDLE, `convolution`=0, `idx`=0, `blank`=1, `busy`=0, `done`=0, timer=0, snapshot buffer=0.
- **IDLE, `start_d`=1, `stop`=0:**
  - Capture all eight inputs into the buffer.
  - `convolution`←`C_11_2x2`, `idx`←0, `blank`←0, `busy`←1, timer←0, go to SHOW.
- **SHOW:**
  - Timer increments each cycle.
  - At timer==DWELL_CYCLES-1 with GAP_CYCLES>0: `blank`←1, timer←0, go to GAP.
  - At that count with GAP_CYCLES==0: apply the advance rule directly.
- **GAP:**
  - `convolution` and `idx` hold their values; `blank`=1.
  - At timer==GAP_CYCLES-1: apply the advance rule.
- **Advance rule:**
  - If `idx`<7: `idx`+1, `convolution`←buf[`idx`+1], `blank`←0, timer←0, go to SHOW.
  - If `idx`==7 and `loop_en`=1: `idx`←0, `convolution`←buf[0], go to SHOW.
  - If `idx`==7 and `loop_en`=0: go to IDLE with `busy`←0, `blank`←1, `convolution`←0, `idx`←0, `done`←1 for exactly one cycle.
- **`stop`=1 in any state:** next edge goes to IDLE with `busy`=0, `blank`=1, `convolution`=0, `idx`=0. No `done`.
- **`start_d` while busy:** ignored. No restart and no re-snapshot.
- **Input changes after capture:** never affect the displayed values. Only a new start takes a new snapshot.
- **`loop_en`:** sampled only at the advance from idx 7.
- **Reset mid-sequence:** identical to the reset values above. The buffer is cleared.

## Timing
- Start latency: value idx 0 is visible the cycle after the edge where `start_d` is sampled.
- Each value is shown for exactly DWELL_CYCLES cycles, followed by exactly GAP_CYCLES blank cycles.
- One pass takes 8·(DWELL_CYCLES+GAP_CYCLES) cycles from the start edge to the edge that sets `done`.
- `done` is high in the first IDLE cycle. A `start_d` in that same cycle is accepted.
- `stop` and `start_d` high together in IDLE: stay in IDLE.

## Structure
- **Package `disp_pkg`:**
  - state enum (IDLE, SHOW, GAP)
  - `NUM_RESULTS`=8
  - `IDX_W`=3
  - `RES_W`=8
- **Sub-module `dwell_timer`:**
  - Inputs: `clear`, `enable`, `terminal` count.
  - Output: `expire` pulse, asserted when count==terminal-1.
  - One instance is shared between the SHOW and GAP phases.
- The snapshot buffer is an 8×8 register array indexed by `idx`.

## Test plan
All scenarios use DWELL=4, GAP=2, inputs 0x11..0x88 in port order.
- **Single pass:** pulse `start_d` → `convolution` shows 0x11,0x22,…,0x88, each for 4 cycles with `blank`=0, separated by 2 blank cycles; `done` pulses at start+48; `busy` is then 0.
- **Loop:** `loop_en`=1 → after 0x88 and its gap, 0x11 reappears with `idx`=0; `done` never asserts.
- **Stop mid-sequence:** assert `stop` during idx 3 SHOW → next cycle `busy`=0, `blank`=1, `convolution`=0, `idx`=0, `done`=0.
- **Snapshot hold and busy start:** change all inputs to 0xFF and pulse `start_d` at idx 2 → sequence continues with the original values and timing unchanged.
- **GAP_CYCLES=0:** values change back-to-back every 4 cycles; `blank` stays 0 until completion; `done` pulses at start+32.
- **Reset mid-sequence:** drive `reset`=0 for one edge at idx 5 → all outputs at reset values; a following `start_d` restarts at idx 0 with the new snapshot.
